mem_port_arbiter: RTL and testbench

- Single owner of the 16-bit external memory port (Addr/RD/WR/DataOut/DataIn).
- Shares the port between four requesters: instruction fetch (IF), vector load (VLD), vector store (VST) and scalar store (SST).
- Sequences 16-beat vector bursts and single-word scalar/fetch accesses.
- Gathers VLD beats into a 256-bit buffer and slices VST vectors into words. Sits between the control FSM/datapath and the SRAM.

---
 rtl/mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sole owner of the 16-bit SRAM port, sequencing fetch, vector load/store
// and scalar store transfers. Define ARB_RR_EN for round-robin instead of fixed priority.
module mem_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int BURST_LEN = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    if_req,
  input  logic [AW-1:0]           if_addr,
  output logic [DW-1:0]           if_data,
  output logic                    if_done,
  input  logic                    vld_req,
  input  logic [AW-1:0]           vld_addr,
  output logic [DW*BURST_LEN-1:0] vld_data,
  output logic                    vld_done,
  input  logic                    vst_req,
  input  logic [AW-1:0]           vst_addr,
  input  logic [DW*BURST_LEN-1:0] vst_data,
  output logic                    vst_done,
  input  logic                    sst_req,
  input  logic [AW-1:0]           sst_addr,
  input  logic [DW-1:0]           sst_data,
  output logic                    sst_done,
  output logic [AW-1:0]           Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [DW-1:0]           DataOut,
  input  logic [DW-1:0]           DataIn,
  output logic                    busy,
  output logic [1:0]              grant
);

  localparam int VW = DW * BURST_LEN;
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  localparam logic [1:0] ID_IF  = 2'd0;
  localparam logic [1:0] ID_VLD = 2'd1;
  localparam logic [1:0] ID_VST = 2'd2;
  localparam logic [1:0] ID_SST = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [3:0]     req_s;
  logic           win_valid_s;
  logic [1:0]     win_id_s;
  logic           win_read_s;
  logic [AW-1:0]  win_addr_s;
  logic [VW-1:0]  win_wdata_s;
  logic           grant_en_s;

  logic [AW-1:0]  base_r;
  logic [VW-1:0]  wdata_r;
  logic [BW-1:0]  beat_r;
  logic           is_read_s;
  logic           is_burst_s;
  logic           last_beat_s;

  logic [AW-1:0]  addr_nx_s;
  logic           rd_nx_s;
  logic           wr_nx_s;
  logic [DW-1:0]  dout_nx_s;
  logic [BW-1:0]  beat_nx_s;
  logic [3:0]     done_nx_s;
  logic           busy_nx_s;

  logic           cap_valid_r;
  logic [BW-1:0]  cap_idx_r;
  logic [DW-1:0]  wword_s [BURST_LEN];
  logic [DW-1:0]  vbuf_r  [BURST_LEN];

  // Word views of the latched store vector and of the load gather buffer
  for (genvar g = 0; g < BURST_LEN; g++) begin : g_slice
    assign wword_s[g]              = wdata_r[g*DW +: DW];
    assign vld_data[g*DW +: DW]    = vbuf_r[g];
  end

  assign req_s      = {sst_req, vst_req, vld_req, if_req};
  assign grant_en_s = (state_r == IDLE) && win_valid_s;
  assign win_read_s = (win_id_s == ID_IF) || (win_id_s == ID_VLD);
  assign is_read_s  = (grant == ID_IF) || (grant == ID_VLD);
  assign is_burst_s = (grant == ID_VLD) || (grant == ID_VST);
  assign last_beat_s = is_burst_s ? (beat_r == LAST_BEAT) : (beat_r == {BW{1'b0}});

`ifdef ARB_RR_EN
  logic [1:0] ptr_r;

  // Round-robin search: first requester strictly after the last owner, wrapping 3 -> 0
  function automatic logic [2:0] pick_rr(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      res = req[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  assign {win_valid_s, win_id_s} = pick_rr(req_s, ptr_r);

  // Remember the last owner so the next search starts just past it
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_r <= 2'd3;
    end else if (grant_en_s) begin
      ptr_r <= win_id_s;
    end
  end
`else
  function automatic logic [2:0] pick_fixed(input logic [3:0] req);
    logic [2:0] res;
    if (req[3]) begin
      res = {1'b1, ID_SST};
    end else if (req[2]) begin
      res = {1'b1, ID_VST};
    end else if (req[1]) begin
      res = {1'b1, ID_VLD};
    end else if (req[0]) begin
      res = {1'b1, ID_IF};
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  assign {win_valid_s, win_id_s} = pick_fixed(req_s);
`endif

  // Address and write data belonging to the arbitration winner
  always_comb begin
    win_addr_s  = if_addr;
    win_wdata_s = {VW{1'b0}};
    case (win_id_s)
      ID_IF: begin
        win_addr_s  = if_addr;
        win_wdata_s = {VW{1'b0}};
      end
      ID_VLD: begin
        win_addr_s  = vld_addr;
        win_wdata_s = {VW{1'b0}};
      end
      ID_VST: begin
        win_addr_s  = vst_addr;
        win_wdata_s = vst_data;
      end
      ID_SST: begin
        win_addr_s  = sst_addr;
        win_wdata_s = {{(VW-DW){1'b0}}, sst_data};
      end
      default: begin
        win_addr_s  = if_addr;
        win_wdata_s = {VW{1'b0}};
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: reads need one drain cycle for the final beat
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_nx_s = XFER;
        end else begin
          state_nx_s = IDLE;
        end
      end
      XFER: begin
        if (last_beat_s) begin
          state_nx_s = is_read_s ? DRAIN : DONE;
        end else begin
          state_nx_s = XFER;
        end
      end
      DRAIN:   state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered port signals and the beat counter
  always_comb begin
    addr_nx_s = Addr;
    rd_nx_s   = 1'b0;
    wr_nx_s   = 1'b0;
    dout_nx_s = DataOut;
    beat_nx_s = beat_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          addr_nx_s = win_addr_s;
          beat_nx_s = {BW{1'b0}};
          rd_nx_s   = win_read_s;
          wr_nx_s   = !win_read_s;
          dout_nx_s = win_wdata_s[DW-1:0];
        end else begin
          beat_nx_s = {BW{1'b0}};
        end
      end
      XFER: begin
        if (!last_beat_s) begin
          beat_nx_s = beat_r + {{(BW-1){1'b0}}, 1'b1};
          addr_nx_s = base_r + {{(AW-BW){1'b0}}, beat_nx_s};
          rd_nx_s   = is_read_s;
          wr_nx_s   = !is_read_s;
          dout_nx_s = is_read_s ? DataOut : wword_s[beat_nx_s];
        end else begin
          rd_nx_s = 1'b0;
          wr_nx_s = 1'b0;
        end
      end
      DRAIN, DONE: begin
        rd_nx_s = 1'b0;
        wr_nx_s = 1'b0;
      end
      default: begin
        rd_nx_s = 1'b0;
        wr_nx_s = 1'b0;
      end
    endcase

    if (state_nx_s == DONE) begin
      done_nx_s = 4'b0001 << grant;
    end else begin
      done_nx_s = 4'b0000;
    end
    busy_nx_s = (state_nx_s != IDLE);
  end

  // Port, handshake and per-transfer context registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Addr     <= {AW{1'b0}};
      RD       <= 1'b0;
      WR       <= 1'b0;
      DataOut  <= {DW{1'b0}};
      beat_r   <= {BW{1'b0}};
      busy     <= 1'b0;
      grant    <= 2'd0;
      base_r   <= {AW{1'b0}};
      wdata_r  <= {VW{1'b0}};
      if_done  <= 1'b0;
      vld_done <= 1'b0;
      vst_done <= 1'b0;
      sst_done <= 1'b0;
    end else begin
      Addr     <= addr_nx_s;
      RD       <= rd_nx_s;
      WR       <= wr_nx_s;
      DataOut  <= dout_nx_s;
      beat_r   <= beat_nx_s;
      busy     <= busy_nx_s;
      {sst_done, vst_done, vld_done, if_done} <= done_nx_s;
      if (grant_en_s) begin
        grant   <= win_id_s;
        base_r  <= win_addr_s;
        wdata_r <= win_wdata_s;
      end
    end
  end

  // Read capture: DataIn belongs to the beat strobed one cycle earlier
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cap_valid_r <= 1'b0;
      cap_idx_r   <= {BW{1'b0}};
      if_data     <= {DW{1'b0}};
      for (int k = 0; k < BURST_LEN; k++) begin
        vbuf_r[k] <= {DW{1'b0}};
      end
    end else begin
      cap_valid_r <= RD;
      cap_idx_r   <= beat_r;
      if (cap_valid_r) begin
        if (grant == ID_IF) begin
          if_data <= DataIn;
        end else begin
          vbuf_r[cap_idx_r] <= DataIn;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: SRAM model, bus logger and a transaction-level
// reference (arbitration order, latency, beat addresses/data, memory contents).
module tb_mem_port_arbiter;

  localparam int LAT [4] = '{3, 18, 17, 2};

  logic          Clk;
  logic          Reset_n;
  logic          if_req, vld_req, vst_req, sst_req;
  logic [15:0]   if_addr, vld_addr, vst_addr, sst_addr;
  logic [15:0]   if_data;
  logic [255:0]  vld_data;
  logic [255:0]  vst_data;
  logic [15:0]   sst_data;
  logic          if_done, vld_done, vst_done, sst_done;
  logic [15:0]   Addr;
  logic          RD, WR;
  logic [15:0]   DataOut;
  logic [15:0]   DataIn;
  logic          busy;
  logic [1:0]    grant;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_id    = 3;

  logic [15:0]  t_addr [4];
  logic [255:0] t_vec;
  logic [15:0]  t_sst;

  logic [15:0] mem     [0:65535];
  bit          wrt     [0:65535];
  logic [15:0] ref_mem [0:65535];
  bit          ref_wrt [0:65535];

  logic        log_rd   [0:255];
  logic        log_wr   [0:255];
  logic        log_busy [0:255];
  logic [15:0] log_addr [0:255];
  logic [15:0] log_dout [0:255];

  mem_port_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .vld_req(vld_req), .vld_addr(vld_addr), .vld_data(vld_data), .vld_done(vld_done),
    .vst_req(vst_req), .vst_addr(vst_addr), .vst_data(vst_data), .vst_done(vst_done),
    .sst_req(sst_req), .sst_addr(sst_addr), .sst_data(sst_data), .sst_done(sst_done),
    .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn),
    .busy(busy), .grant(grant)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Power-on memory contents, including the words the directed cases rely on
  function automatic logic [15:0] init_word(input logic [15:0] a);
    logic [15:0] lo;
    if (a == 16'h0040) return 16'hBEEF;
    if (a >= 16'h0100 && a <= 16'h010F) begin
      lo = {12'h000, a[3:0]};
      return 16'(lo * 16'h1111);
    end
    return 16'((a * 16'd7) ^ 16'h3C3C);
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return wrt[a] ? mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wrt[a] ? ref_mem[a] : init_word(a);
  endfunction

  // Synchronous SRAM: read data valid the cycle after RD
  always @(posedge Clk) begin
    if (WR) begin
      mem[Addr] <= DataOut;
      wrt[Addr] <= 1'b1;
    end
    DataIn <= RD ? mem_rd(Addr) : 16'h0000;
  end

  // Per-cycle bus log, sampled mid-cycle
  always @(negedge Clk) begin
    log_rd[cyc & 255]   <= RD;
    log_wr[cyc & 255]   <= WR;
    log_busy[cyc & 255] <= busy;
    log_addr[cyc & 255] <= Addr;
    log_dout[cyc & 255] <= DataOut;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Which pending requester the arbiter should serve next
  function automatic int model_pick(input logic [3:0] pend, input int last);
`ifdef ARB_RR_EN
    for (int k = 1; k <= 4; k++) if (pend[(last + k) % 4]) return (last + k) % 4;
`else
    for (int k = 3; k >= 0; k--) if (pend[k] && last >= 0) return k;
`endif
    return -1;
  endfunction

  task automatic check_txn(input int id, input int d);
    int n, g, c;
    logic [15:0] a, w;
    logic rd_exp;
    logic [255:0] rv;
    n = (id == 1 || id == 2) ? 16 : 1;
    rd_exp = (id == 0 || id == 1);
    g = d - LAT[id];
    chk("busy_at_grant", log_busy[g & 255], 1'b0);
    for (int j = 0; j < n; j++) begin
      c = g + 1 + j;
      a = t_addr[id] + 16'(j);
      chk("strobe", {log_rd[c & 255], log_wr[c & 255]}, {rd_exp, !rd_exp});
      chk("addr", log_addr[c & 255], a);
      chk("busy_beat", log_busy[c & 255], 1'b1);
      if (!rd_exp) begin
        w = (id == 3) ? t_sst : t_vec[16*j +: 16];
        chk("dataout", log_dout[c & 255], w);
        ref_mem[a] = w;
        ref_wrt[a] = 1'b1;
      end
    end
    c = g + n + 1;
    chk("strobe_off", {log_rd[c & 255], log_wr[c & 255]}, 2'b00);
    if (id == 0) begin
      chk("if_data", if_data, ref_rd(t_addr[0]));
    end else if (id == 1) begin
      for (int j = 0; j < 16; j++) rv[16*j +: 16] = ref_rd(t_addr[1] + 16'(j));
      chk("vld_data", vld_data, rv);
    end
  endtask

  // Raise the requests in mask from an idle cycle and follow them to completion
  task automatic service(input logic [3:0] mask);
    logic [3:0] pend, dn;
    int exp_id, exp_done, got, budget;
    @(negedge Clk); #1;
    if_addr = t_addr[0]; vld_addr = t_addr[1]; vst_addr = t_addr[2]; sst_addr = t_addr[3];
    vst_data = t_vec; sst_data = t_sst;
    {sst_req, vst_req, vld_req, if_req} = mask;
    pend = mask;
    exp_id = model_pick(pend, last_id);
    exp_done = cyc + LAT[exp_id];
    budget = 0;
    while (pend != 4'b0000 && budget < 60) begin
      @(negedge Clk); #1;
      budget++;
      dn = {sst_done, vst_done, vld_done, if_done};
      chk("rd_wr_excl", RD & WR, 1'b0);
      chk("done_onehot", $countones(dn) <= 1, 1'b1);
      if (dn != 4'b0000) begin
        got = 0;
        for (int k = 0; k < 4; k++) if (dn[k]) got = k;
        chk("order", got, exp_id);
        chk("done_cycle", cyc, exp_done);
        chk("grant", grant, got);
        chk("busy_done", busy, 1'b1);
        check_txn(got, cyc);
        case (got)
          0: if_req = 1'b0;
          1: vld_req = 1'b0;
          2: vst_req = 1'b0;
          default: sst_req = 1'b0;
        endcase
        pend[got] = 1'b0;
        last_id = got;
        budget = 0;
        if (pend != 4'b0000) begin
          exp_id = model_pick(pend, last_id);
          exp_done = cyc + 1 + LAT[exp_id];
        end
      end
    end
    chk("all_served", pend, 4'b0000);
    {sst_req, vst_req, vld_req, if_req} = 4'b0000;
  endtask

  initial begin
    logic found, seen;
    Reset_n = 1'b0;
    {if_req, vld_req, vst_req, sst_req} = 4'b0000;
    if_addr = 16'h0; vld_addr = 16'h0; vst_addr = 16'h0; sst_addr = 16'h0;
    vst_data = '0; sst_data = 16'h0;
    t_vec = '0; t_sst = 16'h0;
    for (int k = 0; k < 4; k++) t_addr[k] = 16'h0;

    repeat (2) @(negedge Clk);
    #1;
    chk("rst_rd", RD, 1'b0);
    chk("rst_wr", WR, 1'b0);
    chk("rst_addr", Addr, 16'h0);
    chk("rst_dout", DataOut, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'd0);
    chk("rst_dones", {if_done, vld_done, vst_done, sst_done}, 4'b0000);
    chk("rst_if_data", if_data, 16'h0);
    chk("rst_vld_data", vld_data, 256'h0);
    Reset_n = 1'b1;

    // Single fetch
    t_addr[0] = 16'h0040;
    service(4'b0001);
    chk("if_plan", if_data, 16'hBEEF);

    // Vector load with patterned memory
    t_addr[1] = 16'h0100;
    service(4'b0010);
    for (int i = 0; i < 16; i++) chk("vld_plan", vld_data[16*i +: 16], 16'(i * 16'h1111));

    // Vector store wrapping past 0xFFFF, then read it back
    t_addr[2] = 16'hFFF8;
    for (int i = 0; i < 16; i++) t_vec[16*i +: 16] = 16'hA000 + 16'(i);
    service(4'b0100);
    t_addr[1] = 16'hFFF8;
    service(4'b0010);
    chk("vst_readback", vld_data[16*8 +: 16], 16'hA008);

    // All four at once
    t_addr[0] = 16'h1000; t_addr[1] = 16'h2000; t_addr[2] = 16'h3000; t_addr[3] = 16'h4000;
    t_sst = 16'h5555;
    for (int k = 0; k < 8; k++) t_vec[32*k +: 32] = $urandom;
    service(4'b1111);

    // Scalar store competing with a vector load
    t_addr[3] = 16'h0200; t_sst = 16'h1234; t_addr[1] = 16'h01F8;
    service(4'b1010);

    // Reset in the middle of a vector load
    @(negedge Clk); #1;
    vld_addr = 16'h0300; vld_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge Clk); #1;
      if (RD && Addr == 16'h0307) found = 1'b1;
    end
    chk("reach_beat7", found, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("abort_rd", RD, 1'b0);
    chk("abort_addr", Addr, 16'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_grant", grant, 2'd0);
    vld_req = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge Clk); #1;
      if (vld_done) seen = 1'b1;
    end
    Reset_n = 1'b1;
    last_id = 3;
    repeat (3) begin
      @(negedge Clk); #1;
      if (vld_done) seen = 1'b1;
    end
    chk("no_vld_done", seen, 1'b0);
    t_addr[0] = 16'h0041;
    service(4'b0001);

    // Randomized mixes
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 4; k++) t_addr[k] = 16'($urandom);
      for (int k = 0; k < 8; k++) t_vec[32*k +: 32] = $urandom;
      t_sst = 16'($urandom);
      service(4'($urandom_range(1, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
